// File: rtl/vr_wheel_gen_if.sv
// Wheel generator control/observation bundle: run controls in, synthetic
// crank/cam signals and tooth position out.
interface vr_wheel_gen_if #(
  parameter int PRESC_W = 8,
  parameter int HALF_W  = 16
);
  logic               en;
  logic [PRESC_W-1:0] presc;
  logic [HALF_W-1:0]  half;
  logic               vr_out;
  logic               cam_out;
  logic [7:0]         tooth_idx;
  logic               tooth_stb;
  logic               rev_stb;

  modport master (
    output en, presc, half,
    input  vr_out, cam_out, tooth_idx, tooth_stb, rev_stb
  );

  modport slave (
    input  en, presc, half,
    output vr_out, cam_out, tooth_idx, tooth_stb, rev_stb
  );
endinterface

// File: rtl/vr_wheel_gen.sv
// Synthetic 60-2 style VR crank and cam generator: prescaled tick counter
// shapes each tooth, the last present tooth stretches across the missing gap.
module vr_wheel_gen #(
  parameter int TOOTH_NUM = 60,
  parameter int GAP_NUM   = 2,
  parameter int PRESC_W   = 8,
  parameter int HALF_W    = 16,
  parameter int CAM_LEN   = 4
) (
  input  logic           clk,
  input  logic           rst,
  vr_wheel_gen_if.slave  bus
);
  localparam int         TOP_W    = HALF_W + 9;
  localparam logic [7:0] LAST_IDX = 8'(TOOTH_NUM - GAP_NUM - 1);
  localparam logic [8:0] GAP_MUL  = 9'((GAP_NUM + 1) * 2);
  localparam logic [7:0] CAM_IDX  = 8'(CAM_LEN);

  logic [PRESC_W-1:0] pcnt, presc_s;
  logic [HALF_W-1:0]  half_s, half_in;
  logic [TOP_W-1:0]   tcnt, top, mul;
  logic [7:0]         idx, idx_nxt;
  logic               rph, rph_nxt;
  logic               vr, cam, tstb, rstb;
  logic               tick, is_gap, tooth_end;

  assign half_in   = (bus.half == '0) ? HALF_W'(1) : bus.half;
  assign is_gap    = (idx == LAST_IDX);
  assign mul       = is_gap ? TOP_W'(GAP_MUL) : TOP_W'(2);
  assign top       = TOP_W'(half_s) * mul - TOP_W'(1);
  assign tick      = (pcnt == presc_s) & bus.en;
  assign tooth_end = tick & (tcnt == top);
  assign idx_nxt   = is_gap ? 8'd0 : idx + 8'd1;
  assign rph_nxt   = rph ^ is_gap;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt    <= '0;
      tcnt    <= '0;
      idx     <= '0;
      rph     <= 1'b0;
      vr      <= 1'b0;
      cam     <= 1'b0;
      tstb    <= 1'b0;
      rstb    <= 1'b0;
      presc_s <= bus.presc;
      half_s  <= half_in;
    end else begin
      tstb <= 1'b0;
      rstb <= 1'b0;
      if (bus.en) begin
        pcnt <= tick ? '0 : pcnt + 1'b1;
        if (tooth_end) begin
          // New tooth: operating point is latched here and held for the tooth.
          tcnt    <= '0;
          vr      <= 1'b0;
          idx     <= idx_nxt;
          rph     <= rph_nxt;
          cam     <= rph_nxt & (idx_nxt < CAM_IDX);
          tstb    <= 1'b1;
          rstb    <= (idx_nxt == 8'd0);
          presc_s <= bus.presc;
          half_s  <= half_in;
        end else if (tick) begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == (top >> 1))
            vr <= 1'b1;
        end
      end
    end
  end

  assign bus.vr_out    = vr;
  assign bus.cam_out   = cam;
  assign bus.tooth_idx = idx;
  assign bus.tooth_stb = tstb;
  assign bus.rev_stb   = rstb;
endmodule

// File: tb/tb_vr_wheel_gen.sv
// Scoreboard bench for vr_wheel_gen: a tooth-level timing model predicts each
// tooth start, a monitor checks the DUT against those predictions.
module tb_vr_wheel_gen;
  localparam int TOOTH_NUM = 60;
  localparam int GAP_NUM   = 2;
  localparam int PRESC_W   = 8;
  localparam int HALF_W    = 16;
  localparam int CAM_LEN   = 4;
  localparam int LAST      = TOOTH_NUM - GAP_NUM - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vr_wheel_gen_if #(.PRESC_W(PRESC_W), .HALF_W(HALF_W)) bus ();

  vr_wheel_gen #(
    .TOOTH_NUM(TOOTH_NUM), .GAP_NUM(GAP_NUM), .PRESC_W(PRESC_W),
    .HALF_W(HALF_W), .CAM_LEN(CAM_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int cyc;
    int idx;
    int rev;
    int cam;
    int lo;
    int hi;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tooth length in clk from the wheel rules: 2*half ticks per normal tooth,
  // gap tooth spans GAP_NUM+1 tooth pitches, each tick is presc+1 clk.
  function automatic int tooth_len(input int idx, input int p, input int h);
    int hh;
    hh = (h == 0) ? 1 : h;
    return (p + 1) * 2 * hh * ((idx == LAST) ? GAP_NUM + 1 : 1);
  endfunction

  // Reference model: counts enabled clocks against the predicted tooth length.
  int m_cyc = 0, m_idx = 0, m_rph = 0, m_el = 0, m_len = 0, acc_lo = 0, acc_hi = 0;
  always @(posedge clk) begin
    m_cyc++;
    if (!rst) begin
      m_idx  = 0;
      m_rph  = 0;
      m_el   = 0;
      m_len  = tooth_len(0, int'(bus.presc), int'(bus.half));
      acc_lo = 1;
      acc_hi = 0;
    end else begin
      if (bus.en) begin
        m_el++;
        if (m_el == m_len) begin
          ev_t e;
          int nidx;
          nidx = (m_idx == LAST) ? 0 : m_idx + 1;
          if (m_idx == LAST) m_rph = 1 - m_rph;
          e.cyc = m_cyc;
          e.idx = nidx;
          e.rev = (nidx == 0) ? 1 : 0;
          e.cam = (m_rph == 1 && nidx < CAM_LEN) ? 1 : 0;
          e.lo  = acc_lo;
          e.hi  = acc_hi;
          sb.push_back(e);
          m_idx  = nidx;
          m_el   = 0;
          m_len  = tooth_len(nidx, int'(bus.presc), int'(bus.half));
          acc_lo = 0;
          acc_hi = 0;
        end
      end
      if (2 * m_el >= m_len) acc_hi++;
      else acc_lo++;
    end
  end

  // Monitor
  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= rst;

  int n_cyc = 0, mon_lo = 0, mon_hi = 0, held_idx = 0, held_cam = 0;
  always @(negedge clk) begin
    n_cyc++;
    if (!rst_seen) begin
      check("reset_outputs",
            {bus.vr_out, bus.cam_out, bus.tooth_stb, bus.rev_stb, bus.tooth_idx}, 0);
      mon_lo   = 1;
      mon_hi   = 0;
      held_idx = 0;
      held_cam = 0;
    end else if (bus.tooth_stb) begin
      if (sb.size() == 0) begin
        check("unexpected_tooth_stb", 1, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("tooth_start_cycle", n_cyc, e.cyc);
        check("tooth_idx", bus.tooth_idx, e.idx);
        check("rev_stb", bus.rev_stb, e.rev);
        check("cam_out", bus.cam_out, e.cam);
        check("vr_low_clks", mon_lo, e.lo);
        check("vr_high_clks", mon_hi, e.hi);
        check("vr_at_tooth_start", bus.vr_out, 0);
        held_idx = e.idx;
        held_cam = e.cam;
      end
      mon_lo = bus.vr_out ? 0 : 1;
      mon_hi = bus.vr_out ? 1 : 0;
    end else begin
      if (sb.size() != 0) begin
        ev_t e;
        e = sb.pop_front();
        check("missing_tooth_stb", 0, 1);
        held_idx = e.idx;
        held_cam = e.cam;
      end
      check("hold_rev_idx_cam", {bus.rev_stb, bus.tooth_idx, bus.cam_out},
            {1'b0, 8'(held_idx), 1'(held_cam)});
      if (bus.vr_out) mon_hi++;
      else mon_lo++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tooth(input int idx, input int budget);
    int k;
    bit found;
    k = 0;
    found = 0;
    while (!found && k < budget) begin
      @(posedge clk);
      #1;
      k++;
      found = bus.tooth_stb && (int'(bus.tooth_idx) == idx);
    end
    if (!found) check("wait_tooth_timeout", 0, 1);
  endtask

  initial begin
    bus.en    = 1'b1;
    bus.presc = 8'd3;
    bus.half  = 16'd32;
    rst       = 1'b0;
    cycles(3);
    rst = 1'b1;

    // Two full default revolutions: timing, cam in second rev only
    cycles(2 * 15360 + 300);

    // half changed 32->16 at clk 100 of tooth 5
    wait_tooth(5, 20000);
    cycles(99);
    bus.half = 16'd16;
    wait_tooth(7, 2000);
    bus.half = 16'd32;

    // 50 clk stall in the low half of tooth 10
    wait_tooth(10, 4000);
    cycles(70);
    bus.en = 1'b0;
    cycles(50);
    bus.en = 1'b1;

    // Degenerate fastest wheel
    bus.presc = 8'd0;
    bus.half  = 16'd0;
    cycles(400);

    // Reset pulse inside the gap tooth, then a full revolution after release
    bus.half = 16'd32;
    wait_tooth(LAST, 20000);
    cycles(100);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    cycles(3840 + 200);

    // Randomized operating points, enable jitter and occasional resets
    for (int it = 0; it < 40; it++) begin
      int len;
      bus.presc = 8'($urandom_range(0, 3));
      bus.half  = 16'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        cycles($urandom_range(1, 3));
        rst = 1'b1;
      end
      len = $urandom_range(20, 400);
      for (int c = 0; c < len; c++) begin
        bus.en = ($urandom_range(0, 9) != 0);
        cycles(1);
      end
    end
    bus.en = 1'b1;
    cycles(5);

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vr_wheel_gen.md
VR_WHEEL_GEN -- requirements
Module: vr_wheel_gen

Interface
REQ-001 Parameter TOOTH_NUM, 60: physical teeth per revolution, missing teeth included; range 3..255.
REQ-002 Parameter GAP_NUM, 2: missing teeth forming the gap; range 1..TOOTH_NUM-2.
REQ-003 Parameter PRESC_W, 8: prescaler width.
REQ-004 Parameter HALF_W, 16: tooth half-period width, in prescaled ticks.
REQ-005 Parameter CAM_LEN, 4: cam pulse length, in teeth.
REQ-006 clk  in  1  system clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low.
REQ-008 en  in  1  run enable; low freezes all state.
REQ-009 presc  in  PRESC_W  prescaler value; tick period is presc+1 clk.
REQ-010 half  in  HALF_W  normal tooth half-period in ticks; 0 is treated as 1.
REQ-011 vr_out  out  1  synthetic VR/crank signal.
REQ-012 cam_out  out  1  cam phase signal, one pulse per two revolutions.
REQ-013 tooth_idx  out  8  current tooth index, 0..TOOTH_NUM-GAP_NUM-1.
REQ-014 tooth_stb  out  1  one-clk strobe on the first clk of each tooth.
REQ-015 rev_stb  out  1  one-clk strobe on the first clk of tooth 0.

Function
REQ-016 Prescaler pcnt SHALL count 0..presc_s; tick = (pcnt==presc_s) & en; on tick pcnt returns to 0.
REQ-017 Tick counter tcnt SHALL advance by 1 per tick, 0..top, then return to 0 and start the next tooth.
REQ-018 Normal tooth: top = 2*half_s-1.
REQ-019 Gap tooth (tooth_idx==TOOTH_NUM-GAP_NUM-1): top = (GAP_NUM+1)*2*half_s-1.
REQ-020 top SHALL be computed in HALF_W+9 bits with no overflow or truncation.
REQ-021 vr_out SHALL be 0 at tooth start and SHALL go 1 on the tick after tcnt==top>>1.
REQ-022 vr_out SHALL stay 1 until the tooth ends, then return to 0 on the same edge that starts the next tooth.
REQ-023 tooth_idx SHALL increment at each tooth end; at the gap-tooth end it SHALL wrap to 0.
REQ-024 At the gap-tooth end, the 1-bit revolution phase rph SHALL toggle.
REQ-025 presc and half SHALL be captured into presc_s and half_s on the edge that starts each tooth; changes mid-tooth have no effect until the next tooth.
REQ-026 tooth_stb SHALL pulse for 1 clk registered with each tooth start; rev_stb SHALL pulse coincident with tooth_stb when tooth_idx becomes 0.
REQ-027 cam_out SHALL be 1 iff rph==1 and tooth_idx<CAM_LEN, updated in the same cycle as tooth_idx.
REQ-028 en low SHALL freeze pcnt, tcnt, tooth_idx, rph and vr_out/cam_out; strobes SHALL be 0; en high SHALL resume with no lost or extra tick.
REQ-029 Any wheel state SHALL be reachable without glitches: one register per output, no combinational output paths.

Reset
REQ-030 rst==0 at a clk edge SHALL force pcnt=0, tcnt=0, tooth_idx=0, rph=0, vr_out=0, cam_out=0, tooth_stb=0, rev_stb=0, presc_s=presc, half_s=max(half,1).
REQ-031 Reset mid-tooth or mid-gap SHALL discard the partial tooth.
REQ-032 The first clk after reset release SHALL count as the start of tooth 0, with no tooth_stb or rev_stb pulse.
REQ-033 Reset SHALL take priority over en.

Verification
REQ-034 Defaults, presc=3, half=32, en=1 -> normal tooth 256 clk (vr low 128 / high 128); gap tooth 768 clk (low 384 / high 384); revolution 15360 clk; 58 tooth_stb per rev_stb.
REQ-035 Same setup, two revolutions -> cam_out high 1024 clk in the second revolution only, starting with tooth 0; low throughout the first.
REQ-036 half changed 32->16 at clk 100 of tooth 5 -> tooth 5 stays 256 clk; tooth 6 is 128 clk.
REQ-037 half=0, presc=0 -> normal tooth 2 clk (vr 1 clk low, 1 clk high); gap tooth 6 clk.
REQ-038 en low for 50 clk mid-tooth -> that tooth measures 256+50 clk; outputs held constant; no strobes during the stall.
REQ-039 rst low for 1 clk inside the gap tooth -> all outputs 0 next clk; next rev_stb exactly 15360 clk after release.
